sid_note_sequencer: RTL and testbench

- Queues notes from a host or pattern ROM and plays them one at a time on the single SID voice.
- Each cycle it drives the voice's frequency, duration, attack, sustain and waveform inputs.
- Gates each note for a programmed length, holds a fixed release gap, then starts the next queued note.
- Sits directly in front of the voice as its only sequencer.

---
 rtl/sid_note_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sid_note_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_note_sequencer.sv
`timescale 1ns/1ps
// sid_note_sequencer: note FIFO plus gate/release sequencer for one SID voice.
// Queued notes play in order. Each note is gated for max(len,1) ticks, then
// followed by a fixed release gap of REL_TICKS ticks before the next note.
// The timing is exact because the tick divider restarts whenever PLAY or REL is entered.
module sid_note_sequencer #(
    parameter int DEPTH     = 4,
    parameter int TICK_DIV  = 256,
    parameter int REL_TICKS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic [15:0]              note_freq,
    input  logic [7:0]               note_wave,
    input  logic [7:0]               note_len,
    input  logic [7:0]               cfg_attack,
    input  logic [7:0]               cfg_sustain,
    input  logic [7:0]               cfg_release,
    input  logic                     stop,
    output logic [15:0]              frequency,
    output logic [7:0]               waveform,
    output logic [7:0]               duration,
    output logic [7:0]               attack,
    output logic [7:0]               sustain,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CNW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [31:0]     mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CNW-1:0]  cnt_r;
    logic [7:0]      timer_r, timer_s;
    logic [15:0]     freq_r, freq_s;
    logic [7:0]      wave_r, wave_s;
    logic [7:0]      attack_r, sustain_r, duration_r;
    logic            push_s, pop_s, can_pop_s, enter_s, tick_s;
    logic [31:0]     head_s;
    logic [7:0]      head_len_s;

    // A push in the same cycle as stop is dropped along with the flushed contents.
    assign note_ready = (count_r != CW'(DEPTH));
    assign push_s     = note_valid && note_ready && !stop;
    assign can_pop_s  = (count_r != {CW{1'b0}}) && !stop;
    assign tick_s     = (cnt_r == CNW'(TICK_DIV - 1));
    assign head_s     = mem_r[rd_ptr_r];
    assign head_len_s = (head_s[7:0] == 8'd0) ? 8'd1 : head_s[7:0];

    assign frequency  = freq_r;
    assign waveform   = wave_r;
    assign duration   = duration_r;
    assign attack     = attack_r;
    assign sustain    = sustain_r;
    assign busy       = (state_r != ST_IDLE);
    assign fifo_count = count_r;

    // Note storage: {freq, wave, len} written at the tail.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {note_freq, note_wave, note_len};
        end
    end

    // FIFO pointers and occupancy; stop empties the FIFO by aligning the read pointer to the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (stop) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tick divider; held at zero while idle and restarted on every PLAY/REL entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNW{1'b0}};
        end else if (enter_s || (state_r == ST_IDLE) || tick_s) begin
            cnt_r <= {CNW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNW'(1'b1);
        end
    end

    // Sequencer next state: pops a note, times the gate, and times the release gap.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        freq_s  = freq_r;
        wave_s  = wave_r;
        pop_s   = 1'b0;
        enter_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wave_s[0] = 1'b0;
                if (can_pop_s) begin
                    pop_s   = 1'b1;
                    enter_s = 1'b1;
                    state_s = ST_PLAY;
                    freq_s  = head_s[31:16];
                    wave_s  = {head_s[15:9], 1'b1};
                    timer_s = head_len_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop || (tick_s && (timer_r == 8'd1))) begin
                    wave_s[0] = 1'b0;
                    timer_s   = 8'(REL_TICKS);
                    state_s   = ST_REL;
                    enter_s   = 1'b1;
                end else if (tick_s) begin
                    timer_s = timer_r - 8'd1;
                end else begin
                    timer_s = timer_r;
                end
            end
            ST_REL: begin
                if (tick_s && (timer_r == 8'd1)) begin
                    if (can_pop_s) begin
                        pop_s   = 1'b1;
                        enter_s = 1'b1;
                        state_s = ST_PLAY;
                        freq_s  = head_s[31:16];
                        wave_s  = {head_s[15:9], 1'b1};
                        timer_s = head_len_s;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (tick_s) begin
                    timer_s = timer_r - 8'd1;
                end else begin
                    timer_s = timer_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                wave_s[0] = 1'b0;
            end
        endcase
    end

    // Sequencer state and voice frequency/waveform registers; reset drops the gate at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= 8'd0;
            freq_r  <= 16'd0;
            wave_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            freq_r  <= freq_s;
            wave_r  <= wave_s;
        end
    end

    // Envelope configuration passes straight through with one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            attack_r   <= 8'd0;
            sustain_r  <= 8'd0;
            duration_r <= 8'd0;
        end else begin
            attack_r   <= cfg_attack;
            sustain_r  <= cfg_sustain;
            duration_r <= cfg_release;
        end
    end

endmodule

// File: tb/tb_sid_note_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for sid_note_sequencer.
// The driver issues notes. The monitor keeps a queue of notes that have been accepted
// but not yet started, and checks each note's start, gate length and release gap
// against the rules max(len,1)*TD and REL*TD.
module tb_sid_note_sequencer;

    localparam int DEPTH = 4;
    localparam int TD    = 4;
    localparam int REL   = 2;
    localparam int RT    = REL * TD;

    typedef struct packed {
        logic [15:0] f;
        logic [7:0]  w;
        logic [7:0]  l;
    } note_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        note_valid, note_ready, stop;
    logic [15:0] note_freq;
    logic [7:0]  note_wave, note_len;
    logic [7:0]  cfg_attack, cfg_sustain, cfg_release;
    logic [15:0] frequency;
    logic [7:0]  waveform, duration, attack, sustain;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    sid_note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD), .REL_TICKS(REL)) dut (
        .clk(clk), .rst(rst),
        .note_valid(note_valid), .note_ready(note_ready),
        .note_freq(note_freq), .note_wave(note_wave), .note_len(note_len),
        .cfg_attack(cfg_attack), .cfg_sustain(cfg_sustain), .cfg_release(cfg_release),
        .stop(stop),
        .frequency(frequency), .waveform(waveform), .duration(duration),
        .attack(attack), .sustain(sustain), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    note_t       exp_q[$];
    note_t       cur, pre_note;
    int          phase = 0;
    int          hi_cnt, lo_cnt, glen, q_before;
    logic        pre_valid, pre_stop, g, exp_g;
    logic [7:0]  pre_att, pre_sus, pre_rel;

    task automatic start_note();
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL note_start: gate rose with no queued note (t=%0t)", $time);
            phase = 0;
        end else begin
            cur    = exp_q.pop_front();
            glen   = ((cur.l == 8'd0) ? 1 : int'(cur.l)) * TD;
            chk("start_freq", frequency, cur.f);
            chk("start_wave", waveform, {cur.w[7:1], 1'b1});
            phase  = 1;
            hi_cnt = 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk); #2;
            pre_valid = note_valid;
            pre_stop  = stop;
            pre_note  = {note_freq, note_wave, note_len};
            pre_att   = cfg_attack;
            pre_sus   = cfg_sustain;
            pre_rel   = cfg_release;
            @(posedge clk); #1;
            if (rst) begin
                exp_q.delete();
                phase = 0;
            end else begin
                if (pre_stop) exp_q.delete();
                q_before = exp_q.size();
                if (pre_valid && !pre_stop && (exp_q.size() != DEPTH)) exp_q.push_back(pre_note);
                chk("attack", attack, pre_att);
                chk("sustain", sustain, pre_sus);
                chk("duration", duration, pre_rel);
                g = waveform[0];
                case (phase)
                    0: begin
                        chk("idle_pop", g, q_before != 0);
                        if (g) start_note();
                    end
                    1: begin
                        exp_g = !(pre_stop || (hi_cnt == glen));
                        chk("gate", g, exp_g);
                        chk("play_freq", frequency, cur.f);
                        if (g) begin
                            chk("play_wave", waveform, {cur.w[7:1], 1'b1});
                            hi_cnt++;
                        end else begin
                            chk("fall_wave", waveform, {cur.w[7:1], 1'b0});
                            phase  = 2;
                            lo_cnt = 1;
                        end
                    end
                    default: begin
                        if (lo_cnt == RT) begin
                            chk("rel_end", g, q_before != 0);
                            if (g) start_note();
                            else phase = 0;
                        end else begin
                            chk("rel_gate", g, 1'b0);
                            chk("rel_freq", frequency, cur.f);
                            chk("rel_wave", waveform, {cur.w[7:1], 1'b0});
                            lo_cnt++;
                        end
                    end
                endcase
                chk("fifo_count", fifo_count, exp_q.size());
                chk("note_ready", note_ready, exp_q.size() != DEPTH);
                chk("busy", busy, phase != 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cfg_attack = 8'd0; cfg_sustain = 8'd0; cfg_release = 8'd0;
        forever begin
            @(negedge clk);
            cfg_attack  = 8'($urandom);
            cfg_sustain = 8'($urandom);
            cfg_release = 8'($urandom);
        end
    end

    task automatic push(input logic [15:0] f, input logic [7:0] w, input logic [7:0] l);
        bit ok = 1'b0;
        note_valid = 1'b1; note_freq = f; note_wave = w; note_len = l;
        for (int k = 0; k < 100 && !ok; k++) begin
            #1;
            if (note_ready) ok = 1'b1;
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: note_ready stayed low for 100 cycles");
        end
    endtask

    task automatic wait_idle(input int bound);
        bit done = 1'b0;
        note_valid = 1'b0;
        for (int k = 0; k < bound && !done; k++) begin
            @(negedge clk);
            if (!busy && fifo_count == 3'd0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: busy=%0d count=%0d after %0d cycles", busy, fifo_count, bound);
        end
    endtask

    initial begin
        rst = 1'b1; note_valid = 1'b0; stop = 1'b0;
        note_freq = 16'd0; note_wave = 8'd0; note_len = 8'd0;
        #2;
        chk("rst_freq", frequency, 16'd0);
        chk("rst_wave", waveform, 8'd0);
        chk("rst_dur", duration, 8'd0);
        chk("rst_att", attack, 8'd0);
        chk("rst_sus", sustain, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ready", note_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single note from the test plan
        push(16'h1234, 8'h20, 8'd3);
        wait_idle(100);

        // six back-to-back notes: fills the FIFO and stalls on full
        for (int i = 0; i < 6; i++) push(16'($urandom), 8'($urandom), 8'($urandom_range(0, 3)));
        wait_idle(300);

        // zero length behaves as one tick
        push(16'hBEEF, 8'h41, 8'd0);
        wait_idle(60);

        // stop mid-note with three notes queued
        push(16'h0F0F, 8'h10, 8'd3);
        for (int i = 0; i < 3; i++) push(16'($urandom), 8'($urandom), 8'($urandom_range(0, 3)));
        note_valid = 1'b0;
        repeat (5) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(100);

        // push lands on the same edge as the release-to-play pop at count 2
        push(16'h1111, 8'h20, 8'd1);
        push(16'h2222, 8'h40, 8'd1);
        push(16'h3333, 8'h80, 8'd2);
        note_valid = 1'b0;
        repeat (10) @(negedge clk);
        push(16'h4444, 8'h12, 8'd1);
        wait_idle(200);

        // asynchronous reset in the middle of a note
        push(16'h5A5A, 8'h20, 8'd3);
        push(16'h6B6B, 8'h40, 8'd2);
        note_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_freq", frequency, 16'd0);
        chk("arst_wave", waveform, 8'd0);
        chk("arst_count", fifo_count, 3'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", note_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push(16'h7C7C, 8'h10, 8'd2);
        wait_idle(100);

        // randomized traffic with occasional stop
        for (int c = 0; c < 300; c++) begin
            note_valid = ($urandom_range(0, 2) != 0);
            note_freq  = 16'($urandom);
            note_wave  = 8'($urandom);
            note_len   = 8'($urandom_range(0, 2));
            stop       = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        stop = 1'b0;
        wait_idle(400);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
